// File: rtl/uart_frame_parser.sv
// uart_frame_parser
// Pops bytes from the UART RX FIFO, hunts for SYNC_BYTE, then parses
// frames of the form SYNC, LEN, LEN payload bytes, CHK, where
// CHK = LEN ^ payload[0] ^ ... ^ payload[LEN-1]. Payload bytes are
// streamed out, one status pulse is raised per frame, and saturating
// frame/error counters are kept.
//
// Optional feature, macro UART_PARSER_TIMEOUT_EN: abort a frame in
// progress after TIMEOUT_CYCLES cycles without a new byte (error code 3).
// Without the macro the parser waits for the next byte indefinitely.
//
// Handshakes:
//   FIFO side: o_fifo_rd_en pops one byte, which appears on i_fifo_data
//   in the following cycle. At most one pop is outstanding, and a pop is
//   never issued while i_fifo_empty is high.
//   Stream side: a byte transfers in a cycle where o_m_valid & i_m_ready;
//   o_m_data/o_m_last hold stable while o_m_valid & !i_m_ready.
module uart_frame_parser #(
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
   parameter int unsigned MAX_LEN        = 16,
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_fifo_empty,
   input  logic [7:0]  i_fifo_data,
   output logic        o_fifo_rd_en,
   output logic [7:0]  o_m_data,
   output logic        o_m_valid,
   input  logic        i_m_ready,
   output logic        o_m_last,
   output logic        o_frame_ok,
   output logic        o_frame_err,
   output logic [1:0]  o_err_code,
   output logic [15:0] o_frame_cnt,
   output logic [15:0] o_err_cnt,
   output logic [1:0]  o_dbg_state
);

   typedef enum logic [1:0] {
      ST_HUNT    = 2'd0,
      ST_LEN     = 2'd1,
      ST_PAYLOAD = 2'd2,
      ST_CHK     = 2'd3
   } state_t;

   localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

   state_t     state;
   logic       rd_pending;
   logic [7:0] remaining;
   logic [7:0] chk;
   logic       out_room;
   logic       timeout_hit;

   // Room in the output register: empty, or its byte leaves this cycle.
   assign out_room = !o_m_valid || i_m_ready;

   // Every state consumes bytes; only PAYLOAD also needs output room.
   assign o_fifo_rd_en = !rst && !i_fifo_empty && !rd_pending && !timeout_hit &&
                         ((state != ST_PAYLOAD) || out_room);

   assign o_dbg_state = state;

`ifdef UART_PARSER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] idle_cnt;
   logic          stalled;

   // Downstream backpressure must never count as an idle line.
   assign stalled     = o_m_valid && !i_m_ready;
   assign timeout_hit = (state != ST_HUNT) && !rd_pending && !stalled &&
                        (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

   // Idle counter: cleared by each captured byte and while hunting.
   always_ff @(posedge clk) begin
      if (rst || rd_pending || state == ST_HUNT) begin
         idle_cnt <= '0;
      end else if (!stalled) begin
         idle_cnt <= idle_cnt + TW'(1);
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // Frame FSM, read tracking, output register and status/counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_HUNT;
         rd_pending  <= 1'b0;
         remaining   <= 8'd0;
         chk         <= 8'd0;
         o_m_data    <= 8'd0;
         o_m_valid   <= 1'b0;
         o_m_last    <= 1'b0;
         o_frame_ok  <= 1'b0;
         o_frame_err <= 1'b0;
         o_err_code  <= 2'd0;
         o_frame_cnt <= 16'd0;
         o_err_cnt   <= 16'd0;
      end else begin
         o_frame_ok  <= 1'b0;
         o_frame_err <= 1'b0;
         rd_pending  <= o_fifo_rd_en;

         if (o_m_valid && i_m_ready) begin
            o_m_valid <= 1'b0;
            o_m_last  <= 1'b0;
         end

         if (timeout_hit) begin
            o_frame_err <= 1'b1;
            o_err_code  <= 2'd3;
            if (o_err_cnt != 16'hFFFF) o_err_cnt <= o_err_cnt + 16'd1;
            o_m_valid   <= 1'b0;
            o_m_last    <= 1'b0;
            state       <= ST_HUNT;
         end else if (rd_pending) begin
            case (state)
               ST_HUNT: begin
                  if (i_fifo_data == SYNC_BYTE) state <= ST_LEN;
               end
               ST_LEN: begin
                  if (i_fifo_data == 8'd0 || i_fifo_data > MAX_LEN_B) begin
                     o_frame_err <= 1'b1;
                     o_err_code  <= 2'd1;
                     if (o_err_cnt != 16'hFFFF) o_err_cnt <= o_err_cnt + 16'd1;
                     state       <= ST_HUNT;
                  end else begin
                     remaining <= i_fifo_data;
                     chk       <= i_fifo_data;
                     state     <= ST_PAYLOAD;
                  end
               end
               ST_PAYLOAD: begin
                  o_m_data  <= i_fifo_data;
                  o_m_valid <= 1'b1;
                  o_m_last  <= (remaining == 8'd1);
                  chk       <= chk ^ i_fifo_data;
                  // remaining stops at 1 when the frame's last byte arrives
                  if (remaining == 8'd1) state <= ST_CHK;
                  else remaining <= remaining - 8'd1;
               end
               ST_CHK: begin
                  if (i_fifo_data == chk) begin
                     o_frame_ok <= 1'b1;
                     if (o_frame_cnt != 16'hFFFF) o_frame_cnt <= o_frame_cnt + 16'd1;
                  end else begin
                     o_frame_err <= 1'b1;
                     o_err_code  <= 2'd2;
                     if (o_err_cnt != 16'hFFFF) o_err_cnt <= o_err_cnt + 16'd1;
                  end
                  state <= ST_HUNT;
               end
               default: state <= ST_HUNT;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Testbench for uart_frame_parser: a behavioural RX FIFO feeds byte
// vectors from a table; payload, status pulses, error codes and counters
// are compared against hand-computed values, plus reset, empty-FIFO and
// timeout sequences.
module tb_uart_frame_parser;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        i_fifo_empty = 1'b1;
   logic [7:0]  i_fifo_data = 8'd0;
   logic        o_fifo_rd_en;
   logic [7:0]  o_m_data;
   logic        o_m_valid;
   logic        i_m_ready = 1'b0;
   logic        o_m_last;
   logic        o_frame_ok;
   logic        o_frame_err;
   logic [1:0]  o_err_code;
   logic [15:0] o_frame_cnt;
   logic [15:0] o_err_cnt;
   logic [1:0]  o_dbg_state;

   uart_frame_parser #(
      .SYNC_BYTE      (8'hA5),
      .MAX_LEN        (16),
      .TIMEOUT_CYCLES (20)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .i_fifo_empty (i_fifo_empty),
      .i_fifo_data  (i_fifo_data),
      .o_fifo_rd_en (o_fifo_rd_en),
      .o_m_data     (o_m_data),
      .o_m_valid    (o_m_valid),
      .i_m_ready    (i_m_ready),
      .o_m_last     (o_m_last),
      .o_frame_ok   (o_frame_ok),
      .o_frame_err  (o_frame_err),
      .o_err_code   (o_err_code),
      .o_frame_cnt  (o_frame_cnt),
      .o_err_cnt    (o_err_cnt),
      .o_dbg_state  (o_dbg_state)
   );

   // ---------------- FIFO model and monitors ----------------
   logic [7:0] fifo_q[$];
   logic [8:0] got_q[$];
   logic [8:0] exp_q[$];

   int   cyc = 0;
   int   ok_pulses = 0;
   int   err_pulses = 0;
   logic [1:0] last_code = 2'd0;
   int   last_err_cyc = 0;
   int   last_xfer_cyc = 0;
   int   pop_empty_viol = 0;
   int   dbl_viol = 0;
   int   blk_viol = 0;
   int   stab_viol = 0;
   int   both_viol = 0;
   logic prev_rst = 1'b1;
   logic prev_rd = 1'b0;
   logic prev_hold = 1'b0;
   logic [8:0] prev_word = 9'd0;

   // Empty flag follows the queue, updated away from the active edge.
   always @(negedge clk) i_fifo_empty <= (fifo_q.size() == 0);

   // Pops, stream transfers, status pulses and protocol rule watchers.
   always @(posedge clk) begin
      cyc      <= cyc + 1;
      prev_rst <= rst;
      prev_rd  <= o_fifo_rd_en;
      if (o_fifo_rd_en) begin
         if (fifo_q.size() == 0) pop_empty_viol <= pop_empty_viol + 1;
         else i_fifo_data <= fifo_q.pop_front();
      end
      if (prev_rd && o_fifo_rd_en) dbl_viol <= dbl_viol + 1;
      if (o_fifo_rd_en && o_dbg_state == 2'd2 && o_m_valid && !i_m_ready)
         blk_viol <= blk_viol + 1;
      if (!rst && o_m_valid && i_m_ready) begin
         got_q.push_back({o_m_last, o_m_data});
         last_xfer_cyc <= cyc;
      end
      if (!prev_rst && prev_hold && (!o_m_valid || {o_m_last, o_m_data} != prev_word))
         stab_viol <= stab_viol + 1;
      prev_hold <= o_m_valid && !i_m_ready && !rst;
      prev_word <= {o_m_last, o_m_data};
      if (o_frame_ok) ok_pulses <= ok_pulses + 1;
      if (o_frame_err) begin
         err_pulses   <= err_pulses + 1;
         last_code    <= o_err_code;
         last_err_cyc <= cyc;
      end
      if (o_frame_ok && o_frame_err) both_viol <= both_viol + 1;
   end

   // ---------------- driver tasks and checker ----------------
   int checks = 0;
   int errors = 0;
   int stall_cfg = 0;
   int hold_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // One cycle; i_m_ready goes high after stall_cfg cycles of a held byte.
   task automatic tick();
      @(negedge clk);
      if (o_m_valid) begin
         if (hold_cnt >= stall_cfg) begin
            i_m_ready = 1'b1;
            hold_cnt  = 0;
         end else begin
            i_m_ready = 1'b0;
            hold_cnt++;
         end
      end else begin
         i_m_ready = (stall_cfg == 0);
         hold_cnt  = 0;
      end
   endtask

   task automatic push(input logic [7:0] b);
      fifo_q.push_back(b);
   endtask

   // ---------------- vector table ----------------
   typedef struct packed {
      logic [0:19][7:0] b;      // FIFO bytes in arrival order
      logic [4:0]       n;
      logic [7:0]       stall;  // ready-low cycles per payload byte
      logic [0:15][8:0] exp;    // {last, data} in transfer order
      logic [4:0]       n_exp;
      logic             exp_ok;
      logic             exp_err;
      logic [1:0]       exp_code;
   } vec_t;

   localparam int NV = 8;
   vec_t vecs [NV];

   initial begin
      int exp_frames;
      int exp_errs;
      int base_ok;
      int base_err;
      int rd_high;
      bit done;

      for (int v = 0; v < NV; v++) vecs[v] = '0;
      // good frame: CHK = 03^11^22^33 = 03
      vecs[0].b[0:5] = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
      vecs[0].n = 6; vecs[0].exp[0:2] = {9'h011, 9'h022, 9'h133}; vecs[0].n_exp = 3;
      vecs[0].exp_ok = 1'b1;
      // garbage before the sync byte is dropped silently
      vecs[1].b[0:5] = {8'h00, 8'hFF, 8'hA5, 8'h01, 8'h7E, 8'h7F};
      vecs[1].n = 6; vecs[1].exp[0] = 9'h17E; vecs[1].n_exp = 1; vecs[1].exp_ok = 1'b1;
      // zero length
      vecs[2].b[0:1] = {8'hA5, 8'h00};
      vecs[2].n = 2; vecs[2].exp_err = 1'b1; vecs[2].exp_code = 2'd1;
      // length 17 > MAX_LEN
      vecs[3].b[0:1] = {8'hA5, 8'h11};
      vecs[3].n = 2; vecs[3].exp_err = 1'b1; vecs[3].exp_code = 2'd1;
      // bad checksum (expected 32) under 10-cycle backpressure
      vecs[4].b[0:4] = {8'hA5, 8'h02, 8'h10, 8'h20, 8'h00};
      vecs[4].n = 5; vecs[4].stall = 8'd10;
      vecs[4].exp[0:1] = {9'h010, 9'h120}; vecs[4].n_exp = 2;
      vecs[4].exp_err = 1'b1; vecs[4].exp_code = 2'd2;
      // length 16 == MAX_LEN, payload 01..10: CHK = 10 ^ (01^..^10) = 00
      vecs[5].b[0] = 8'hA5; vecs[5].b[1] = 8'h10;
      for (int i = 0; i < 16; i++) begin
         vecs[5].b[2+i]  = 8'(i + 1);
         vecs[5].exp[i]  = {(i == 15), 8'(i + 1)};
      end
      vecs[5].b[18] = 8'h00; vecs[5].n = 19; vecs[5].n_exp = 16; vecs[5].exp_ok = 1'b1;
      // sync value inside payload is plain data: CHK = 02^A5^A5 = 02
      vecs[6].b[0:4] = {8'hA5, 8'h02, 8'hA5, 8'hA5, 8'h02};
      vecs[6].n = 5; vecs[6].exp[0:1] = {9'h0A5, 9'h1A5}; vecs[6].n_exp = 2;
      vecs[6].exp_ok = 1'b1;
      // single byte frame with a short stall: CHK = 01^5A = 5B
      vecs[7].b[0:3] = {8'hA5, 8'h01, 8'h5A, 8'h5B};
      vecs[7].n = 4; vecs[7].stall = 8'd3; vecs[7].exp[0] = 9'h15A; vecs[7].n_exp = 1;
      vecs[7].exp_ok = 1'b1;

      // ---- reset state ----
      rst = 1'b1;
      repeat (3) tick();
      check("rst_rd_en",     32'(o_fifo_rd_en), 0);
      check("rst_m_valid",   32'(o_m_valid),    0);
      check("rst_m_data",    32'(o_m_data),     0);
      check("rst_m_last",    32'(o_m_last),     0);
      check("rst_frame_ok",  32'(o_frame_ok),   0);
      check("rst_frame_err", 32'(o_frame_err),  0);
      check("rst_err_code",  32'(o_err_code),   0);
      check("rst_frame_cnt", 32'(o_frame_cnt),  0);
      check("rst_err_cnt",   32'(o_err_cnt),    0);
      check("rst_state",     32'(o_dbg_state),  0);
      rst = 1'b0;

      // ---- empty FIFO: no pops ----
      rd_high = 0;
      for (int c = 0; c < 100; c++) begin
         tick();
         if (o_fifo_rd_en) rd_high++;
      end
      check("empty_no_rd_en", 32'(rd_high), 0);

      // ---- table ----
      exp_frames = 0;
      exp_errs   = 0;
      for (int v = 0; v < NV; v++) begin
         base_ok  = ok_pulses;
         base_err = err_pulses;
         got_q.delete();
         exp_q.delete();
         for (int i = 0; i < int'(vecs[v].n_exp); i++) exp_q.push_back(vecs[v].exp[i]);
         stall_cfg = int'(vecs[v].stall);
         for (int i = 0; i < int'(vecs[v].n); i++) push(vecs[v].b[i]);
         done = 1'b0;
         for (int c = 0; c < 3000; c++) begin
            tick();
            if (fifo_q.size() == 0 && got_q.size() >= exp_q.size() && !o_m_valid &&
                (ok_pulses - base_ok + err_pulses - base_err) >=
                (int'(vecs[v].exp_ok) + int'(vecs[v].exp_err))) begin
               done = 1'b1;
               break;
            end
         end
         repeat (3) tick();
         check($sformatf("v%0d_completed", v), 32'(done), 1);
         check($sformatf("v%0d_n_payload", v), 32'(got_q.size()), 32'(exp_q.size()));
         for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size())
               check($sformatf("v%0d_payload%0d", v, i), 32'(got_q[i]), 32'(exp_q[i]));
         end
         check($sformatf("v%0d_ok_pulses", v), 32'(ok_pulses - base_ok), 32'(vecs[v].exp_ok));
         check($sformatf("v%0d_err_pulses", v), 32'(err_pulses - base_err), 32'(vecs[v].exp_err));
         if (vecs[v].exp_err)
            check($sformatf("v%0d_err_code", v), 32'(last_code), 32'(vecs[v].exp_code));
         exp_frames += int'(vecs[v].exp_ok);
         exp_errs   += int'(vecs[v].exp_err);
         check($sformatf("v%0d_frame_cnt", v), 32'(o_frame_cnt), 32'(exp_frames));
         check($sformatf("v%0d_err_cnt", v), 32'(o_err_cnt), 32'(exp_errs));
         check($sformatf("v%0d_state_hunt", v), 32'(o_dbg_state), 0);
      end

      // ---- reset in the middle of a frame ----
      stall_cfg = 1000;
      got_q.delete();
      push(8'hA5); push(8'h02); push(8'h10);
      done = 1'b0;
      for (int c = 0; c < 100; c++) begin
         tick();
         if (o_m_valid) begin
            done = 1'b1;
            break;
         end
      end
      check("mid_payload_loaded", 32'(done), 1);
      check("mid_state_payload", 32'(o_dbg_state), 2);
      rst = 1'b1;
      tick();
      check("mid_rst_m_valid",   32'(o_m_valid),   0);
      check("mid_rst_state",     32'(o_dbg_state), 0);
      check("mid_rst_frame_cnt", 32'(o_frame_cnt), 0);
      check("mid_rst_err_cnt",   32'(o_err_cnt),   0);
      check("mid_rst_err_code",  32'(o_err_code),  0);
      rst = 1'b0;
      stall_cfg = 0;
      repeat (3) tick();
      got_q.delete();

      // ---- idle line after a partial frame ----
      base_err = err_pulses;
      push(8'hA5); push(8'h02); push(8'h10);
      done = 1'b0;
      for (int c = 0; c < 100; c++) begin
         tick();
         if (got_q.size() == 1) begin
            done = 1'b1;
            break;
         end
      end
      check("tmo_first_byte", 32'(done), 1);
`ifdef UART_PARSER_TIMEOUT_EN
      done = 1'b0;
      for (int c = 0; c < 200; c++) begin
         tick();
         if (err_pulses != base_err) begin
            done = 1'b1;
            break;
         end
      end
      tick();
      check("tmo_fired",     32'(done), 1);
      check("tmo_err_code",  32'(last_code), 3);
      check("tmo_delay",     32'(last_err_cyc - last_xfer_cyc), 20);
      check("tmo_m_valid",   32'(o_m_valid), 0);
      check("tmo_state",     32'(o_dbg_state), 0);
      check("tmo_err_cnt",   32'(o_err_cnt), 1);
`else
      repeat (200) tick();
      check("tmo_no_err",      32'(err_pulses - base_err), 0);
      check("tmo_still_wait",  32'(o_dbg_state), 2);
      check("tmo_err_cnt",     32'(o_err_cnt), 0);
`endif

      // ---- protocol rule watchers ----
      check("pop_while_empty",  32'(pop_empty_viol), 0);
      check("two_reads_out",    32'(dbl_viol), 0);
      check("pop_while_blocked", 32'(blk_viol), 0);
      check("stream_stability", 32'(stab_viol), 0);
      check("ok_and_err_same",  32'(both_viol), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
